if_fetch_queue: RTL
===================

# if_fetch_queue

Instruction-fetch stage that consumes the program counter and drives its hold input. Each cycle it issues an instruction-memory read at the current PC over a req/ack handshake. Returned words are buffered with their PC in a small FIFO and handed to decode over valid/ready. The PC is held until its fetch completes, and a flush discards all buffered and in-flight fetches on a branch or jump redirect.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- pc_i  input  32  current PC from the PC register.
- pc_hold_o  output  1  drives PC_Hold; 0 lets the PC load its next value this edge.
- flush_i  input  1  redirect: kill queue and in-flight fetch.
- imem_req_o  output  1  read request, level.
- imem_addr_o  output  32  read address.
- imem_ack_i  input  1  completes the transaction when sampled with imem_req_o=1.
- imem_rdata_i  input  32  instruction word, valid with imem_ack_i.
- id_valid_o  output  1  head entry valid.
- id_ready_i  input  1  decode accepts the head entry.
- id_inst_o  output  32  head instruction.
- id_pc_o  output  32  head PC.

## Operation
- FSM states:
  - RUN, the reset state.
  - DROP, waiting out a killed in-flight transaction.
- Counters and registers: count (0..DEPTH), rd_ptr, wr_ptr, drop_addr.
- imem_req_o = !reset && ((RUN && count<DEPTH) || DROP).
- imem_addr_o = drop_addr in DROP, else pc_i.
- Completion: imem_req_o && imem_ack_i.
- RUN completion without flush_i: enqueue {pc_i, imem_rdata_i} at wr_ptr, then wr_ptr+1 mod DEPTH.
- pc_hold_o = !(flush_i || (RUN && completion)). The PC is never released for a dropped word.
- Dequeue on id_valid_o && id_ready_i: rd_ptr+1 mod DEPTH.
- count: +1 on enqueue only, -1 on dequeue only, unchanged on both.
- flush_i has priority over enqueue, dequeue and the FSM:
  - count, rd_ptr and wr_ptr are cleared to 0.
  - A same-cycle decode handshake is void; decode discards that instruction.
  - If flush_i arrives in RUN with imem_req_o=1 and imem_ack_i=0, capture drop_addr=pc_i and go to DROP.
  - If the ack arrives in the flush cycle, the word is discarded and the FSM stays in RUN.
- DROP: hold req and drop_addr until ack, discard the data, then return to RUN. Further flush_i in DROP only clears the queue.
- id_valid_o = (count!=0). id_inst_o and id_pc_o show the entry at rd_ptr.
- Reset (synchronous) clears the state to RUN, count to 0, both pointers to 0 and drop_addr to 0.
- Output values while reset is high: imem_req_o=0, id_valid_o=0, pc_hold_o=1, imem_addr_o=pc_i.
- Reset mid-transaction abandons it; the memory must tolerate req dropping.

## Timing
- Without bypass: ack in cycle N gives id_valid_o=1 from cycle N+1. The PC advances at the edge ending cycle N.
- Zero-wait memory (ack tied to req) with id_ready_i=1 sustains one instruction per cycle.
- A full queue with no dequeue drops req in the same cycle count reaches DEPTH, computed from the registered count. The PC is held until space frees.
- Redirect: flush in cycle N lets the PC load the target at edge N. The first target fetch is requested in cycle N+1 if the FSM is in RUN; if it is in DROP, the request follows the drop ack.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0 and a RUN completion occurs without flush_i, id_valid_o=1 in the same cycle with id_inst_o=imem_rdata_i and id_pc_o=pc_i.
  - If id_ready_i=1 that cycle, nothing is enqueued and count stays 0.
- FETCH_QUEUE_BYPASS_EN undefined: no combinational path from the imem_* inputs to the id_* outputs; one added cycle of latency.

## Test plan
- Reset, zero-wait memory, id_ready_i=1, PC stepping 0x00400000, 0x00400004, … → from cycle 2 one instruction per cycle, id_pc_o in order; pc_hold_o=1 during reset.
- Memory with 3-cycle ack latency → req held stable with imem_addr_o=0x00400000 for 3 cycles; pc_hold_o=0 only in the ack cycle.
- id_ready_i=0 with DEPTH=4 → exactly 4 entries enqueued; then req=0 and pc_hold_o=1; one id_ready_i pulse issues exactly one new fetch.
- flush_i with queue holding 3 entries and a request outstanding at 0x00400010 → id_valid_o=0 next cycle; FSM in DROP with addr 0x00400010 until ack; data dropped; the next request uses the branch target.
- flush_i in the same cycle as an ack and a decode handshake → count=0, word dropped, pc_hold_o=0.
- With FETCH_QUEUE_BYPASS_EN, empty queue, ack in cycle N → id_valid_o=1 in cycle N with id_inst_o=imem_rdata_i; without the macro → cycle N+1.

Source files
------------

// File: rtl/if_fetch_queue.sv
`timescale 1ns/1ps
// if_fetch_queue: instruction fetch over a req/ack memory port feeding a DEPTH-entry decode queue.
// Optional same-cycle bypass of a returning word to decode when FETCH_QUEUE_BYPASS_EN is defined.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic        pc_hold_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, DROP} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   drop_addr;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic run_cpl;
  logic enq;
  logic deq;

  always_comb begin
    imem_req_o  = !reset && ((state == RUN && count < FULL) || state == DROP);
    imem_addr_o = (!reset && state == DROP) ? drop_addr : pc_i;
    run_cpl     = imem_req_o && imem_ack_i && state == RUN;
    pc_hold_o   = reset || !(flush_i || run_cpl);
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // A word accepted straight from memory is never written; one left waiting is enqueued.
  always_comb begin
    bypass     = count == '0 && run_cpl && !flush_i;
    id_valid_o = !reset && (count != '0 || bypass);
    id_inst_o  = bypass ? imem_rdata_i : inst_mem[rd_ptr];
    id_pc_o    = bypass ? pc_i : pc_mem[rd_ptr];
    enq        = run_cpl && !flush_i && !(bypass && id_ready_i);
    deq        = !reset && count != '0 && id_ready_i;
  end
`else
  always_comb begin
    id_valid_o = !reset && count != '0;
    id_inst_o  = inst_mem[rd_ptr];
    id_pc_o    = pc_mem[rd_ptr];
    enq        = run_cpl && !flush_i;
    deq        = id_valid_o && id_ready_i;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      drop_addr <= '0;
    end else begin
      if (flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        if (enq && !deq)      count <= count + CW'(1);
        else if (deq && !enq) count <= count - CW'(1);
      end
      // A dropped transaction still completes on its ack even if another flush lands then.
      case (state)
        RUN: begin
          if (flush_i && imem_req_o && !imem_ack_i) begin
            state     <= DROP;
            drop_addr <= pc_i;
          end
        end
        DROP: begin
          if (imem_ack_i) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]   <= pc_i;
    end
  end

endmodule
